// File: rtl/timer_wrapper.sv
// timer_wrapper: programmable 16-bit down-counting timer on the CPU register bus.
//
// Register map (bus_address):
//   0 CTRL      bit0 EN, bit1 AUTO, bit2 IE, bits[5:4] PS (tick every 1/16/256/4096 clocks)
//   1 STATUS    bit0 MATCH (sticky, write 1 to clear), bit1 RUN (mirrors EN, read-only)
//   2 COUNT_LO  read-only; reading also snapshots count[15:8] into a shadow register
//   3 COUNT_HI  read-only; returns the shadow so LO-then-HI is an atomic 16-bit read
//   4 RELOAD_LO write stages the low byte (reads 0x00)
//   5 RELOAD_HI write commits {data, staged low} to reload; if EN=0 also loads count (reads 0x00)
//   6,7         reserved: read 0x00, writes ignored
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset
//   bus_address  register select (3 bits)
//   bus_data_tx  write data
//   bus_data_rx  registered read data, valid the cycle after bus_read is first seen
//   bus_read     read strobe, held by the CPU until bus_wait drops
//   bus_write    single-cycle write strobe
//   bus_wait     high during the first cycle of a read
//   irq          level interrupt = MATCH & IE
//
// Build option: define TIMER_IRQ_EN to store CTRL.IE and drive irq; when it is
// undefined, IE reads 0 and irq is tied low (MATCH polling still works).

module timer_wrapper (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] bus_address,
  input  logic [7:0] bus_data_tx,
  output logic [7:0] bus_data_rx,
  input  logic       bus_read,
  input  logic       bus_write,
  output logic       bus_wait,
  output logic       irq
);

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_COUNT_LO  = 3'd2;
  localparam logic [2:0] ADDR_COUNT_HI  = 3'd3;
  localparam logic [2:0] ADDR_RELOAD_LO = 3'd4;
  localparam logic [2:0] ADDR_RELOAD_HI = 3'd5;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DONE = 1'b1
  } rd_state_t;

  rd_state_t   rd_state_reg, rd_state_next;

  logic        en_reg, en_next;
  logic        auto_reg, auto_next;
  logic [1:0]  ps_reg, ps_next;
  logic        ie_reg;
  logic        match_reg, match_next;
  logic [15:0] count_reg, count_next;
  logic [15:0] reload_reg, reload_next;
  logic [7:0]  stage_lo_reg, stage_lo_next;
  logic [7:0]  shadow_reg, shadow_next;
  logic [11:0] presc_reg, presc_next;
  logic [7:0]  rd_data_reg, rd_data_next;

  // Write strobes per register
  logic wr_ctrl, wr_status, wr_reload_lo, wr_reload_hi;
  assign wr_ctrl      = bus_write && (bus_address == ADDR_CTRL);
  assign wr_status    = bus_write && (bus_address == ADDR_STATUS);
  assign wr_reload_lo = bus_write && (bus_address == ADDR_RELOAD_LO);
  assign wr_reload_hi = bus_write && (bus_address == ADDR_RELOAD_HI);

  // A read is accepted only from IDLE; bus_wait covers exactly that cycle.
  logic rd_start;
  assign rd_start = (rd_state_reg == RD_IDLE) && bus_read;
  assign bus_wait = rd_start;

  // Prescaler tap: tick when the low n bits of the prescaler are all ones.
  logic [11:0] presc_mask;
  always_comb begin
    presc_mask = 12'h000;
    unique case (ps_reg)
      2'd0:    presc_mask = 12'h000;
      2'd1:    presc_mask = 12'h00F;
      2'd2:    presc_mask = 12'h0FF;
      default: presc_mask = 12'hFFF;
    endcase
  end

  logic tick, tick_eff;
  assign tick     = en_reg && ((presc_reg & presc_mask) == presc_mask);
  // A CTRL write that clears EN swallows a coincident tick.
  assign tick_eff = tick && !(wr_ctrl && !bus_data_tx[0]);

  // Read mux
  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'h00;
    case (bus_address)
      ADDR_CTRL:     rd_mux = {2'b00, ps_reg, 1'b0, ie_reg, auto_reg, en_reg};
      ADDR_STATUS:   rd_mux = {6'b000000, en_reg, match_reg};
      ADDR_COUNT_LO: rd_mux = count_reg[7:0];
      ADDR_COUNT_HI: rd_mux = shadow_reg;
      default:       rd_mux = 8'h00;
    endcase
  end

  // Datapath next-state
  logic match_set;
  always_comb begin
    en_next       = en_reg;
    auto_next     = auto_reg;
    ps_next       = ps_reg;
    match_next    = match_reg;
    count_next    = count_reg;
    reload_next   = reload_reg;
    stage_lo_next = stage_lo_reg;
    shadow_next   = shadow_reg;
    presc_next    = presc_reg;
    rd_data_next  = rd_data_reg;
    match_set     = 1'b0;

    if (wr_ctrl) begin
      en_next   = bus_data_tx[0];
      auto_next = bus_data_tx[1];
      ps_next   = bus_data_tx[5:4];
    end

    // Restart the prescaler on an EN 0->1 edge so the first period is full length.
    if (wr_ctrl && bus_data_tx[0] && !en_reg) begin
      presc_next = 12'h000;
    end else if (en_reg) begin
      presc_next = presc_reg + 12'h001;
    end

    if (wr_reload_lo) begin
      stage_lo_next = bus_data_tx;
    end
    // reload_next carries a same-cycle RELOAD_HI write so an auto-reload picks it up.
    if (wr_reload_hi) begin
      reload_next = {bus_data_tx, stage_lo_reg};
    end

    if (wr_reload_hi && !en_reg) begin
      count_next = {bus_data_tx, stage_lo_reg};
    end else if (tick_eff) begin
      if (count_reg == 16'h0000) begin
        match_set = 1'b1;
        if (auto_reg) begin
          count_next = reload_next;
        end else if (!wr_ctrl) begin
          // A coincident CTRL write re-arming EN takes priority over the one-shot stop.
          en_next = 1'b0;
        end
      end else begin
        count_next = count_reg - 16'h0001;
      end
    end

    // Clear first, then set, so a coincident match keeps MATCH high.
    if (wr_status && bus_data_tx[0]) begin
      match_next = 1'b0;
    end
    if (match_set) begin
      match_next = 1'b1;
    end

    if (rd_start) begin
      rd_data_next = rd_mux;
      if (bus_address == ADDR_COUNT_LO) begin
        shadow_next = count_reg[15:8];
      end
    end
  end

  // Read FSM next-state
  always_comb begin
    rd_state_next = rd_state_reg;
    unique case (rd_state_reg)
      RD_IDLE: if (bus_read)  rd_state_next = RD_DONE;
      RD_DONE: if (!bus_read) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= RD_IDLE;
      en_reg       <= 1'b0;
      auto_reg     <= 1'b0;
      ps_reg       <= 2'd0;
      match_reg    <= 1'b0;
      count_reg    <= 16'h0000;
      reload_reg   <= 16'h0000;
      stage_lo_reg <= 8'h00;
      shadow_reg   <= 8'h00;
      presc_reg    <= 12'h000;
      rd_data_reg  <= 8'h00;
    end else begin
      rd_state_reg <= rd_state_next;
      en_reg       <= en_next;
      auto_reg     <= auto_next;
      ps_reg       <= ps_next;
      match_reg    <= match_next;
      count_reg    <= count_next;
      reload_reg   <= reload_next;
      stage_lo_reg <= stage_lo_next;
      shadow_reg   <= shadow_next;
      presc_reg    <= presc_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  assign bus_data_rx = rd_data_reg;

`ifdef TIMER_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_reg <= 1'b0;
    end else if (wr_ctrl) begin
      ie_reg <= bus_data_tx[2];
    end
  end
  assign irq = match_reg & ie_reg;
`else
  assign ie_reg = 1'b0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_wrapper.sv
// Self-checking bench for timer_wrapper. Expected read data is pushed to a
// scoreboard queue when a read is issued and popped when the data is valid.
// All stimulus is applied and all outputs sampled around the falling edge.

module tb_timer_wrapper;

`ifdef TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] bus_address = 3'd0;
  logic [7:0] bus_data_tx = 8'h00;
  logic [7:0] bus_data_rx;
  logic       bus_read = 1'b0;
  logic       bus_write = 1'b0;
  logic       bus_wait;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  timer_wrapper dut (
    .clk         (clk),
    .rst         (rst),
    .bus_address (bus_address),
    .bus_data_tx (bus_data_tx),
    .bus_data_rx (bus_data_rx),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_wait    (bus_wait),
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // All tasks start and end on a falling edge.
  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
    logic [7:0] want;
    exp_q.push_back(exp);
    bus_address = a;
    bus_read    = 1'b1;
    #1;
    n_cmp++;
    if (bus_wait !== 1'b1) begin
      n_bad++;
      $display("FAIL %s wait_first: got %b want 1", nm, bus_wait);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_wait !== 1'b0) begin
      n_bad++;
      $display("FAIL %s wait_done: got %b want 0", nm, bus_wait);
    end
    want = exp_q.pop_front();
    n_cmp++;
    if (bus_data_rx !== want) begin
      n_bad++;
      $display("FAIL %s data: got %02h want %02h", nm, bus_data_rx, want);
    end
    $display("rd  %-14s addr=%0d data=%02h exp=%02h cyc=%0d", nm, a, bus_data_rx, want, cyc);
    bus_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_address = a;
    bus_data_tx = d;
    bus_write   = 1'b1;
    #1;
    n_cmp++;
    if (bus_wait !== 1'b0) begin
      n_bad++;
      $display("FAIL write_wait: got %b want 0", bus_wait);
    end
    @(negedge clk);
    bus_write = 1'b0;
    $display("wr  addr=%0d data=%02h cyc=%0d", a, d, cyc);
  endtask

  task automatic wait_to(input int target);
    if (cyc > target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_to: cycle %0d already past %0d", cyc, target);
    end
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus_data_rx !== 8'h00 || bus_wait !== 1'b0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rx=%02h wait=%b irq=%b want 00/0/0", bus_data_rx, bus_wait, irq);
    end
    // Reset must win over a coincident CTRL write.
    rst = 1'b1; bus_address = 3'd0; bus_data_tx = 8'h33; bus_write = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus_write = 1'b0;
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "reset_reg");
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_auto_reload();
    int e0, k;
    logic [7:0] exp;
    do_reset();
    wr(3'd4, 8'h03);
    wr(3'd5, 8'h00);
    wr(3'd0, 8'h03);
    e0 = cyc;
    for (int i = 0; i < 12; i++) begin
      if ((i % 3) == 1) @(negedge clk);
      k = cyc - e0;
      if ((i % 2) == 0) begin
        exp = 8'(3 - (k % 4));
        rd(3'd2, exp, "auto_count");
      end else begin
        exp = {6'b000000, 1'b1, (k >= 4)};
        rd(3'd1, exp, "auto_status");
      end
    end
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    rd(3'd1, 8'h00, "auto_cleared");
  endtask

  task automatic test_one_shot();
    int e0;
    do_reset();
    wr(3'd4, 8'h02);
    wr(3'd5, 8'h00);
    wr(3'd0, 8'h21);
    e0 = cyc;
    wait_to(e0 + 254);
    rd(3'd2, 8'h02, "os_count_2");
    rd(3'd2, 8'h01, "os_count_1");
    wait_to(e0 + 510);
    rd(3'd2, 8'h01, "os_count_1b");
    rd(3'd2, 8'h00, "os_count_0");
    wait_to(e0 + 766);
    rd(3'd1, 8'h02, "os_before");
    rd(3'd1, 8'h01, "os_match");
    rd(3'd0, 8'h20, "os_ctrl");
    wait_to(e0 + 1100);
    rd(3'd2, 8'h00, "os_count_hold");
    rd(3'd1, 8'h01, "os_sticky");
  endtask

  task automatic test_atomic_read();
    int e0;
    do_reset();
    wr(3'd4, 8'hFF);
    wr(3'd5, 8'h01);
    wr(3'd0, 8'h01);
    e0 = cyc;
    rd(3'd2, 8'hFF, "atom_lo");
    wait_to(e0 + 300);
    rd(3'd3, 8'h01, "atom_hi_shadow");
    rd(3'd2, 8'hD1, "atom_lo2");
    rd(3'd3, 8'h00, "atom_hi2");
  endtask

  task automatic test_coincident();
    do_reset();
    // Reload 0 with AUTO: every tick lands on zero.
    wr(3'd0, 8'h03);
    wr(3'd1, 8'h01);
    rd(3'd1, 8'h03, "w1c_vs_set");
    wr(3'd4, 8'h05);
    wr(3'd5, 8'h00);
    rd(3'd2, 8'h05, "reload_same");
    // CTRL clear in a tick cycle must not decrement.
    do_reset();
    wr(3'd4, 8'h0A);
    wr(3'd5, 8'h00);
    wr(3'd0, 8'h01);
    wr(3'd0, 8'h00);
    rd(3'd2, 8'h0A, "clear_tick");
    rd(3'd1, 8'h00, "clear_status");
  endtask

  task automatic test_irq();
    logic [7:0] exp;
    do_reset();
    wr(3'd0, 8'h07);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_pre: got %b want 0", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== IRQ_ON) begin
      n_bad++;
      $display("FAIL irq_first: got %b want %b", irq, IRQ_ON);
    end
    exp = {5'b00000, IRQ_ON, 2'b11};
    rd(3'd0, exp, "irq_ctrl");
    wr(3'd1, 8'h01);
    n_cmp++;
    if (irq !== IRQ_ON) begin
      n_bad++;
      $display("FAIL irq_reset_by_tick: got %b want %b", irq, IRQ_ON);
    end
    wr(3'd0, 8'h04);
    n_cmp++;
    if (irq !== IRQ_ON) begin
      n_bad++;
      $display("FAIL irq_held: got %b want %b", irq, IRQ_ON);
    end
    wr(3'd1, 8'h01);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_cleared: got %b want 0", irq);
    end
    rd(3'd1, 8'h00, "irq_status");
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [7:0] exp;
    do_reset();
    wr(3'd4, 8'h34);
    wr(3'd5, 8'h12);
    wr(3'd0, 8'h03);
    e0 = cyc;
    repeat (5) @(negedge clk);
    exp = 8'(16'h1234 - 16'(cyc - e0));
    bus_address = 3'd2;
    bus_read    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_wait !== 1'b0 || bus_data_rx !== exp) begin
      n_bad++;
      $display("FAIL mid_read: got wait=%b rx=%02h want 0/%02h", bus_wait, bus_data_rx, exp);
    end
    rst = 1'b1;
    bus_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_wait !== 1'b0 || bus_data_rx !== 8'h00 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got wait=%b rx=%02h irq=%b want 0/00/0", bus_wait, bus_data_rx, irq);
    end
    rst = 1'b0;
    @(negedge clk);
    rd(3'd0, 8'h00, "mid_ctrl");
    rd(3'd1, 8'h00, "mid_status");
    rd(3'd2, 8'h00, "mid_count_lo");
    rd(3'd3, 8'h00, "mid_shadow");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_atomic_read();
    test_coincident();
    test_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
